// File: rtl/clock_timekeeper_ctrl_pkg.sv
// Shared types and constants for the clock timekeeper slice.
package clock_pkg;

    // Controller states; the encoding is visible on the mode output.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } mode_t;

    localparam int HH_W = 5;
    localparam int MS_W = 6;

    localparam int HOUR_MAX_DEF = 23;
    localparam int MIN_MAX_DEF  = 59;
    localparam int SEC_MAX_DEF  = 59;

endpackage

// File: rtl/clock_timekeeper_ctrl_if.sv
// Bundle of the per-second tick, button pulses and time/display outputs.
// Signalling: tick, btn_mode and btn_inc are single-cycle pulses sampled on
// the rising clk edge; every output is registered and reflects the pulses of
// the previous edge. min_pulse/hour_pulse are single-cycle strobes.
interface clock_timekeeper_ctrl_if;
    import clock_pkg::*;

    logic            tick;
    logic            btn_mode;
    logic            btn_inc;
    logic [HH_W-1:0] hh;
    logic [MS_W-1:0] mm;
    logic [MS_W-1:0] ss;
    mode_t           mode;
    logic            blink;
    logic            min_pulse;
    logic            hour_pulse;

    modport master (
        output tick, btn_mode, btn_inc,
        input  hh, mm, ss, mode, blink, min_pulse, hour_pulse
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output hh, mm, ss, mode, blink, min_pulse, hour_pulse
    );
endinterface

// File: rtl/clock_timekeeper_ctrl_wrap_counter.sv
// Modulo-(MAX+1) counter; wrap flags that the next increment returns to 0.
module wrap_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    input  logic         clr_sync,
    output logic [W-1:0] value,
    output logic         wrap
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign wrap = (value == MAX_V);

    // Count on inc, folding back to zero after MAX.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            value <= '0;
        end else if (clr_sync) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + W'(1);
        end
    end
endmodule

// File: rtl/clock_timekeeper_ctrl.sv
// Timekeeping and set-mode controller: runs hh:mm:ss from the second tick
// and lets the user set each field with the mode/inc buttons.
module clock_timekeeper_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = HOUR_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int SEC_MAX  = SEC_MAX_DEF
) (
    input logic clk,
    input logic clr,
    clock_timekeeper_ctrl_if.slave bus
);
    mode_t mode_q;
    logic  blink_q;
    logic  min_pulse_q;
    logic  hour_pulse_q;

    logic ss_wrap, mm_wrap, hh_wrap;
    logic ss_inc, mm_inc, hh_inc;
    logic run_tick, set_inc;

    // A mode press in a set state takes priority over a same-cycle inc.
    assign run_tick = (mode_q == RUN) && bus.tick;
    assign set_inc  = (mode_q != RUN) && bus.btn_inc && !bus.btn_mode;

    assign ss_inc = run_tick || (set_inc && mode_q == SET_SS);
    assign mm_inc = (run_tick && ss_wrap) || (set_inc && mode_q == SET_MM);
    assign hh_inc = (run_tick && ss_wrap && mm_wrap) || (set_inc && mode_q == SET_HH);

    wrap_counter #(.W(MS_W), .MAX(SEC_MAX)) u_ss (
        .clk(clk), .clr(clr), .inc(ss_inc), .clr_sync(1'b0),
        .value(bus.ss), .wrap(ss_wrap)
    );

    wrap_counter #(.W(MS_W), .MAX(MIN_MAX)) u_mm (
        .clk(clk), .clr(clr), .inc(mm_inc), .clr_sync(1'b0),
        .value(bus.mm), .wrap(mm_wrap)
    );

    wrap_counter #(.W(HH_W), .MAX(HOUR_MAX)) u_hh (
        .clk(clk), .clr(clr), .inc(hh_inc), .clr_sync(1'b0),
        .value(bus.hh), .wrap(hh_wrap)
    );

    // Mode sequencing plus blink phase: blink restarts visible on every entry
    // into a set state and flips once per second while setting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q  <= RUN;
            blink_q <= 1'b0;
        end else if (bus.btn_mode) begin
            blink_q <= 1'b0;
            case (mode_q)
                RUN:     mode_q <= SET_HH;
                SET_HH:  mode_q <= SET_MM;
                SET_MM:  mode_q <= SET_SS;
                default: mode_q <= RUN;
            endcase
        end else if (mode_q == RUN) begin
            blink_q <= 1'b0;
        end else if (bus.tick) begin
            blink_q <= !blink_q;
        end
    end

    // Carry strobes, only ever produced by a running tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
        end else begin
            min_pulse_q  <= run_tick && ss_wrap;
            hour_pulse_q <= run_tick && ss_wrap && mm_wrap;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.blink      = blink_q;
    assign bus.min_pulse  = min_pulse_q;
    assign bus.hour_pulse = hour_pulse_q;

    // hh_wrap is only needed to keep the counter interface uniform; the
    // hour counter wraps on its own when it increments past HOUR_MAX.
    logic unused_hh_wrap;
    assign unused_hh_wrap = hh_wrap;
endmodule

// File: tb/tb_clock_timekeeper_ctrl.sv
// Bench for clock_timekeeper_ctrl: directed scenarios then random buttons,
// checked against a seconds-of-day reference model.
module tb_clock_timekeeper_ctrl;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;

    clock_timekeeper_ctrl_if bus ();

    clock_timekeeper_ctrl dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model state: time as seconds of the day
    int m_secs;
    int m_mode;
    bit m_blink;
    bit m_minp;
    bit m_hourp;

    logic [21:0] exp_q[$];

    int checks = 0;
    int failures = 0;
    int minp_seen;
    int minp_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] model_vec();
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = 5'(m_secs / 3600);
        m = 6'((m_secs / 60) % 60);
        s = 6'(m_secs % 60);
        return {h, m, s, 2'(m_mode), m_blink, m_minp, m_hourp};
    endfunction

    // Compare every DUT output against the oldest expected entry.
    task automatic check_outputs(input string tag);
        logic [21:0] e;
        e = exp_q.pop_front();
        chk({tag, ".hh"},    32'(bus.hh),         32'(e[21:17]));
        chk({tag, ".mm"},    32'(bus.mm),         32'(e[16:11]));
        chk({tag, ".ss"},    32'(bus.ss),         32'(e[10:5]));
        chk({tag, ".mode"},  32'(bus.mode),       32'(e[4:3]));
        chk({tag, ".blink"}, 32'(bus.blink),      32'(e[2]));
        chk({tag, ".minp"},  32'(bus.min_pulse),  32'(e[1]));
        chk({tag, ".hourp"}, 32'(bus.hour_pulse), 32'(e[0]));
        chk({tag, ".range"}, 32'(bus.hh <= 5'd23 && bus.mm <= 6'd59 && bus.ss <= 6'd59), 32'd1);
    endtask

    // Reference rules applied to one clock cycle of inputs.
    task automatic model_step(input bit t, input bit bm, input bit bi);
        int h, m, s;
        m_minp  = 1'b0;
        m_hourp = 1'b0;
        if (m_mode == 0) begin
            if (t) begin
                m_secs  = (m_secs + 1) % 86400;
                m_minp  = (m_secs % 60) == 0;
                m_hourp = (m_secs % 3600) == 0;
            end
            m_blink = 1'b0;
            if (bm) m_mode = 1;
        end else if (bm) begin
            m_mode  = (m_mode + 1) % 4;
            m_blink = 1'b0;
        end else begin
            if (bi) begin
                h = m_secs / 3600;
                m = (m_secs / 60) % 60;
                s = m_secs % 60;
                if (m_mode == 1) h = (h + 1) % 24;
                if (m_mode == 2) m = (m + 1) % 60;
                if (m_mode == 3) s = (s + 1) % 60;
                m_secs = h * 3600 + m * 60 + s;
            end
            if (t) m_blink = !m_blink;
        end
    endtask

    // Driver: present one cycle of pulses, then check the registered response.
    task automatic step(input bit t, input bit bm, input bit bi, input string tag);
        @(negedge clk);
        bus.tick     = t;
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        model_step(t, bm, bi);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_secs  = 0;
        m_mode  = 0;
        m_blink = 1'b0;
        m_minp  = 1'b0;
        m_hourp = 1'b0;
    endtask

    // Assert clr between edges and check outputs before any edge arrives.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        exp_q.push_back(model_vec());
        check_outputs(tag);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        model_reset();

        // 1: reset, 61 running ticks
        do_reset("t1_reset");
        minp_seen = 0;
        minp_at   = -1;
        for (int i = 1; i <= 61; i++) begin
            step(1, 0, 0, "t1_tick");
            if (bus.min_pulse === 1'b1) begin
                minp_seen++;
                minp_at = i;
            end
        end
        chk("t1_hh", 32'(bus.hh), 32'd0);
        chk("t1_mm", 32'(bus.mm), 32'd1);
        chk("t1_ss", 32'(bus.ss), 32'd1);
        chk("t1_minp_count", 32'(minp_seen), 32'd1);
        chk("t1_minp_at", 32'(minp_at), 32'd60);

        // 2: set 23:59:58 from 00:01:01, then roll over
        step(0, 1, 0, "t2_to_hh");
        for (int i = 0; i < 23; i++) step(0, 0, 1, "t2_inc_hh");
        step(0, 1, 0, "t2_to_mm");
        for (int i = 0; i < 58; i++) step(0, 0, 1, "t2_inc_mm");
        step(0, 1, 0, "t2_to_ss");
        for (int i = 0; i < 57; i++) step(0, 0, 1, "t2_inc_ss");
        chk("t2_preset_hh", 32'(bus.hh), 32'd23);
        chk("t2_preset_mm", 32'(bus.mm), 32'd59);
        chk("t2_preset_ss", 32'(bus.ss), 32'd58);
        step(0, 1, 0, "t2_to_run");
        step(1, 0, 0, "t2_tick1");
        step(1, 0, 0, "t2_tick2");
        chk("t2_roll_hms", 32'({bus.hh, bus.mm, bus.ss}), 32'd0);
        chk("t2_minp", 32'(bus.min_pulse), 32'd1);
        chk("t2_hourp", 32'(bus.hour_pulse), 32'd1);
        step(0, 0, 0, "t2_pulse_end");

        // 3: 25 hour increments wrap to 1; ticks only toggle blink
        step(0, 1, 0, "t3_to_hh");
        for (int i = 0; i < 25; i++) step(0, 0, 1, "t3_inc_hh");
        chk("t3_hh", 32'(bus.hh), 32'd1);
        chk("t3_mode", 32'(bus.mode), 32'(SET_HH));
        for (int i = 0; i < 5; i++) step(1, 0, 0, "t3_set_tick");
        chk("t3_ss", 32'(bus.ss), 32'd0);
        chk("t3_blink", 32'(bus.blink), 32'd1);

        // 4: mode+inc in SET_MM, then tick+mode in SET_SS
        step(0, 1, 0, "t4_to_mm");
        for (int i = 0; i < 10; i++) step(0, 0, 1, "t4_inc_mm");
        step(0, 1, 1, "t4_mode_inc");
        chk("t4_mode", 32'(bus.mode), 32'(SET_SS));
        chk("t4_mm", 32'(bus.mm), 32'd10);
        step(1, 1, 0, "t4_tick_mode");
        chk("t4_run", 32'(bus.mode), 32'(RUN));
        chk("t4_ss", 32'(bus.ss), 32'd0);

        // 5: async reset while setting minutes at 30
        step(0, 1, 0, "t5_to_hh");
        step(0, 1, 0, "t5_to_mm");
        for (int i = 0; i < 20; i++) step(0, 0, 1, "t5_inc_mm");
        chk("t5_mm30", 32'(bus.mm), 32'd30);
        do_reset("t5_reset");
        step(1, 0, 0, "t5_first_tick");
        chk("t5_ss1", 32'(bus.ss), 32'd1);

        // 6: tick+mode in RUN at 00:00:59
        step(0, 1, 0, "t6_to_hh");
        step(0, 1, 0, "t6_to_mm");
        step(0, 1, 0, "t6_to_ss");
        for (int i = 0; i < 58; i++) step(0, 0, 1, "t6_inc_ss");
        step(0, 1, 0, "t6_to_run");
        step(1, 1, 0, "t6_tick_mode");
        chk("t6_mm", 32'(bus.mm), 32'd1);
        chk("t6_ss", 32'(bus.ss), 32'd0);
        chk("t6_mode", 32'(bus.mode), 32'(SET_HH));
        chk("t6_minp", 32'(bus.min_pulse), 32'd1);
        chk("t6_blink", 32'(bus.blink), 32'd0);
        step(0, 0, 0, "t6_pulse_end");

        // Random pulses against the model
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 9) == 0),
                 bit'($urandom_range(0, 2) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_timekeeper_ctrl.md
Name: clock_timekeeper_ctrl

Overview:
Timekeeping and set-mode controller for the digital clock. It consumes the one-cycle-per-second tick from the second-tick generator and sequences the hh:mm:ss counters. It runs a button-driven FSM so the user can set hours, minutes and seconds. Its outputs feed the display multiplexer/7-seg decoder.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 0 (23 = 24h clock)
MIN_MAX, 59, last minute value before wrap to 0
SEC_MAX, 59, last second value before wrap to 0

Ports:
clk  in  1  system clock (100 MHz)
clr  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle pulse, once per second, synchronous to clk
btn_mode  in  1  debounced one-cycle pulse; advances the FSM
btn_inc  in  1  debounced one-cycle pulse; increments the selected field in set mode
hh  out  5  hours, binary, 0..HOUR_MAX
mm  out  6  minutes, binary, 0..MIN_MAX
ss  out  6  seconds, binary, 0..SEC_MAX
mode  out  2  current FSM state encoding (mode_t)
blink  out  1  display-blank phase for the field being set
min_pulse  out  1  one-cycle pulse when ss wraps SEC_MAX->0 in RUN
hour_pulse  out  1  one-cycle pulse when mm wraps MIN_MAX->0 in RUN

Behaviour:
- Reset (clr=1, async):
  - hh=mm=ss=0, mode=RUN, blink=0, min_pulse=hour_pulse=0.
  - Applies mid-operation from any state; takes effect immediately.
- All outputs are registered. Response to tick/btn appears on the next clk edge, so latency is 1 cycle.
- FSM states (mode_t): RUN=0, SET_HH=1, SET_MM=2, SET_SS=3.
  - btn_mode transitions: RUN->SET_HH->SET_MM->SET_SS->RUN.
  - No other transitions exist.
- RUN:
  - tick: ss+1. If ss==SEC_MAX, ss=0, mm+1 and min_pulse=1.
  - If mm also ==MIN_MAX: mm=0, hh+1, hour_pulse=1.
  - If hh also ==HOUR_MAX: hh=0 (full rollover HOUR_MAX:MIN_MAX:SEC_MAX -> 0:0:0 in one cycle).
  - btn_inc ignored.
  - blink held 0.
- SET_xx states:
  - Time is frozen; tick does not advance counters.
  - btn_inc increments the selected field only, wrapping at its MAX to 0.
  - No carry into other fields; min_pulse/hour_pulse stay 0.
  - blink toggles on each tick (1 Hz half-period).
  - blink is forced to 0 on entry to each SET state, so every newly selected field starts visible.
- Leaving SET_SS->RUN: values are kept as set. The next tick advances normally, with no extra or lost tick.
- Simultaneous events:
  - tick+btn_mode in RUN: the tick update is applied and the state moves to SET_HH in the same cycle.
  - btn_mode+btn_inc in a SET state: the mode advance wins; the inc is discarded.
  - tick+btn_inc in a SET state: the inc is applied; the tick only toggles blink.
  - tick+btn_mode in SET_SS: move to RUN; the tick is not applied to counters.
- min_pulse/hour_pulse are exactly 1 cycle wide and never asserted outside RUN.
- Width rules:
  - All compares use the full field width.
  - Out-of-range values are unreachable; the bench asserts this.
  - Increments are unsigned with no overflow beyond MAX.

Decomposition:
- Shared package clock_pkg:
  - typedef enum logic [1:0] mode_t {RUN, SET_HH, SET_MM, SET_SS}.
  - Width constants HH_W=5, MS_W=6.
  - Default MAX constants.
- One natural sub-module, wrap_counter:
  - Parameterised width and MAX.
  - Inputs inc/clr_sync; outputs value and a wrap flag.
  - Instantiated three times for ss/mm/hh.
  - The controller generates the inc enables from FSM state, tick and btn_inc.

Test Plan:
1. Reset then 61 ticks in RUN -> ss=1, mm=1, hh=0; min_pulse high exactly once, on the 60th tick's response cycle.
2. Preload by set mode to 23:59:58, return to RUN, 2 ticks -> 00:00:00; min_pulse and hour_pulse both pulse on the second tick's response cycle.
3. btn_mode x1 then btn_inc x25 -> mode=SET_HH, hh=1 (wrapped at 23); mm, ss unchanged; 5 ticks during set -> ss unchanged, blink toggled 5 times.
4. Same-cycle btn_mode+btn_inc in SET_MM with mm=10 -> mode=SET_SS, mm=10; next btn_mode with tick in the same cycle -> mode=RUN, ss unchanged.
5. Reset asserted mid-SET_MM with mm=30 between clk edges -> outputs 0 and mode=RUN immediately, without waiting for an edge; after release, the first tick gives ss=1.
6. tick+btn_mode same cycle in RUN at 00:00:59 -> 00:01:00, mode=SET_HH, min_pulse=1 for one cycle, blink=0.
